// File: rtl/store_lane_unit_pkg.sv
// Shared store-path encodings: st_op sizes, store FSM states, and the alignment rule.
// Pure definitions: no latency and no backpressure of its own.
package store_lane_unit_pkg;

    typedef enum logic [1:0] {
        ST_W   = 2'b00,
        ST_H   = 2'b01,
        ST_B   = 2'b10,
        ST_RSV = 2'b11
    } st_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } st_state_e;

    // Word stores need a 4-byte boundary, halfwords a 2-byte one; the reserved op never passes.
    function automatic logic st_aligned(input logic [1:0] op, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (op)
            ST_W:    ok = (a == 2'b00);
            ST_H:    ok = ~a[0];
            ST_B:    ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_lane_unit_pack.sv
// Narrows the store operand to its size and places it on byte lanes with enables and legality.
// Purely combinational: zero latency, no backpressure.
module st_lane_pack
    import store_lane_unit_pkg::*;
#(
    parameter int REPLICATE = 1
) (
    input  logic [1:0]  st_op,
    input  logic [1:0]  addr,
    input  logic [31:0] st_data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        legal
);

    always_comb begin
        wdata = 32'h0;
        be    = 4'b0000;
        legal = st_aligned(st_op, addr);
        case (st_op)
            ST_W: begin
                wdata = st_data;
                be    = 4'b1111;
            end
            ST_H: begin
                be = addr[1] ? 4'b1100 : 4'b0011;
                if (REPLICATE != 0) begin
                    wdata = {2{st_data[15:0]}};
                end else begin
                    wdata = addr[1] ? {st_data[15:0], 16'h0} : {16'h0, st_data[15:0]};
                end
            end
            ST_B: begin
                be = 4'b0001 << addr;
                if (REPLICATE != 0) begin
                    wdata = {4{st_data[7:0]}};
                end else begin
                    wdata = {24'h0, st_data[7:0]} << {addr, 3'b000};
                end
            end
            default: begin
                wdata = 32'h0;
                be    = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/store_lane_unit.sv
// Store lane unit: packs a MEM-stage store onto data-memory lanes and runs the req/ack write.
// Latency: done 1 cycle after mem_ack (min 3 cycles), fault done 1 cycle after accept; st_stall holds the pipeline.
module store_lane_unit
    import store_lane_unit_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int REPLICATE = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              st_valid,
    input  logic [1:0]        st_op,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              st_stall,
    output logic              st_done,
    output logic              st_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack
);

    st_state_e         state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              st_done_q, st_done_d;
    logic              st_fault_q, st_fault_d;

    logic [31:0]       pack_wdata;
    logic [3:0]        pack_be;
    logic              pack_legal;

    st_lane_pack #(
        .REPLICATE (REPLICATE)
    ) u_pack (
        .st_op   (st_op),
        .addr    (st_addr[1:0]),
        .st_data (st_data),
        .wdata   (pack_wdata),
        .be      (pack_be),
        .legal   (pack_legal)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (st_valid) begin
                    state_d = pack_legal ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address and data are left untouched after the ack so the port only toggles on a new accept.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        st_done_d   = 1'b0;
        st_fault_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (st_valid) begin
                    if (pack_legal) begin
                        mem_req_d   = 1'b1;
                        mem_be_d    = pack_be;
                        mem_addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = pack_wdata;
                    end else begin
                        st_done_d  = 1'b1;
                        st_fault_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_be_d  = 4'b0000;
                    st_done_d = 1'b1;
                end
            end
            S_DONE: begin
                mem_req_d = 1'b0;
                mem_be_d  = 4'b0000;
            end
            default: begin
                mem_req_d = 1'b0;
                mem_be_d  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_req_q   <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            st_done_q   <= 1'b0;
            st_fault_q  <= 1'b0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            st_done_q   <= st_done_d;
            st_fault_q  <= st_fault_d;
        end
    end

    assign st_stall  = st_valid & ~st_done_q;
    assign st_done   = st_done_q;
    assign st_fault  = st_fault_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_lane_unit.sv
// Bench for store_lane_unit: two instances (replicated and zero-filled lanes) share one stimulus stream.
module tb_store_lane_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        st_valid;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_ack;

    logic        r_st_stall, r_st_done, r_st_fault, r_mem_req, r_mem_we;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        n_st_stall, n_st_done, n_st_fault, n_mem_req, n_mem_we;
    logic [31:0] n_mem_addr, n_mem_wdata;
    logic [3:0]  n_mem_be;

    int checks = 0;
    int errors = 0;

    // Observations gathered by drive_store for the calling test to judge.
    int          o_req_cycles, o_done_cycle;
    logic        o_fault, o_unstable, o_stall_bad, o_after_done, o_done_req;
    logic [3:0]  o_be, o_done_be;
    logic [31:0] o_wd_r, o_wd_n, o_addr, o_done_addr;

    always #5 clk = ~clk;

    store_lane_unit #(.ADDR_W(32), .REPLICATE(1)) u_rep (
        .clk(clk), .rstn(rstn), .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr),
        .st_data(st_data), .st_stall(r_st_stall), .st_done(r_st_done), .st_fault(r_st_fault),
        .mem_req(r_mem_req), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
        .mem_be(r_mem_be), .mem_ack(mem_ack)
    );

    store_lane_unit #(.ADDR_W(32), .REPLICATE(0)) u_nrep (
        .clk(clk), .rstn(rstn), .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr),
        .st_data(st_data), .st_stall(n_st_stall), .st_done(n_st_done), .st_fault(n_st_fault),
        .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
        .mem_be(n_mem_be), .mem_ack(mem_ack)
    );

    // Reference: a store of n bytes at offset a covers lanes a..a+n-1; replicated data repeats every n bytes.
    function automatic void model(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                                  input bit rep, output bit legal, output logic [3:0] be,
                                  output logic [31:0] wd);
        int n;
        int a;
        n     = (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : 1;
        a     = int'(addr % 4);
        legal = (op != 2'd3) && (a % n == 0);
        be    = 4'b0000;
        wd    = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= a && i < a + n) be[i] = 1'b1;
            if (rep) wd[8*i +: 8] = data[8*(i % n) +: 8];
            else if (i >= a && i < a + n) wd[8*i +: 8] = data[8*(i - a) +: 8];
        end
    endfunction

    task automatic drive_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                               input int ack_delay, input bit spurious);
        bit seen;
        seen = 1'b0;
        o_req_cycles = 0; o_done_cycle = -1; o_fault = 1'b0; o_unstable = 1'b0;
        o_stall_bad = 1'b0; o_after_done = 1'b0; o_done_req = 1'b0; o_done_be = 4'b0;
        o_be = 4'b0; o_wd_r = 32'h0; o_wd_n = 32'h0; o_addr = 32'h0; o_done_addr = 32'h0;
        @(posedge clk); #1;
        st_valid = 1'b1; st_op = op; st_addr = addr; st_data = data; mem_ack = spurious;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                mem_ack = r_mem_req ? (cyc == ack_delay) : spurious;
            end
            @(negedge clk);
            if (r_mem_req) begin
                o_req_cycles++;
                if (!seen) begin
                    seen = 1'b1; o_be = r_mem_be; o_wd_r = r_mem_wdata; o_wd_n = n_mem_wdata; o_addr = r_mem_addr;
                end else if (r_mem_be !== o_be || r_mem_wdata !== o_wd_r || r_mem_addr !== o_addr
                             || n_mem_wdata !== o_wd_n) begin
                    o_unstable = 1'b1;
                end
                if (r_mem_we !== 1'b1 || n_mem_be !== r_mem_be) o_unstable = 1'b1;
            end
            if (r_st_stall !== ~r_st_done || n_st_done !== r_st_done || n_st_stall !== r_st_stall)
                o_stall_bad = 1'b1;
            if (r_st_done === 1'b1) begin
                o_done_cycle = cyc; o_fault = r_st_fault; o_done_req = r_mem_req | r_mem_we;
                o_done_be = r_mem_be; o_done_addr = r_mem_addr;
                break;
            end
        end
        @(posedge clk); #1;
        st_valid = 1'b0; mem_ack = spurious;
        @(negedge clk);
        o_after_done = r_st_done | r_st_fault | r_mem_req | n_st_done | n_mem_req;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({r_mem_req, r_mem_we, r_mem_be, r_st_done, r_st_fault} !== 8'h0 || r_mem_addr !== 32'h0
            || r_mem_wdata !== 32'h0 || n_mem_req !== 1'b0 || n_mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b be=%b done=%b fault=%b addr=%h wdata=%h, required all 0",
                     r_mem_req, r_mem_be, r_st_done, r_st_fault, r_mem_addr, r_mem_wdata);
        end
    endtask

    task automatic test_sw;
        drive_store(2'b00, 32'h1000_0004, 32'hDEAD_BEEF, 1, 1'b0);
        checks++;
        if (o_addr !== 32'h1000_0004 || o_be !== 4'b1111 || o_wd_r !== 32'hDEAD_BEEF || o_wd_n !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_fields: addr=%h be=%b wd=%h/%h, required 10000004 1111 deadbeef", o_addr, o_be, o_wd_r, o_wd_n);
        end
        checks++;
        if (o_done_cycle !== 2 || o_fault !== 1'b0 || o_req_cycles !== 1) begin
            errors++;
            $display("FAIL sw_timing: done_cycle=%0d fault=%b req_cycles=%0d, required 2 0 1", o_done_cycle, o_fault, o_req_cycles);
        end
        checks++;
        if (o_done_req !== 1'b0 || o_done_be !== 4'b0 || o_done_addr !== 32'h1000_0004 || o_after_done !== 1'b0) begin
            errors++;
            $display("FAIL sw_done_cycle: req=%b be=%b addr=%h after=%b, required 0 0000 10000004 0",
                     o_done_req, o_done_be, o_done_addr, o_after_done);
        end
    endtask

    task automatic test_sb;
        drive_store(2'b10, 32'h0000_0013, 32'h1234_56A5, 1, 1'b0);
        checks++;
        if (o_addr !== 32'h0000_0010 || o_be !== 4'b1000 || o_wd_r !== 32'hA5A5_A5A5 || o_wd_n !== 32'hA500_0000) begin
            errors++;
            $display("FAIL sb_lanes: addr=%h be=%b rep=%h zero=%h, required 00000010 1000 a5a5a5a5 a5000000",
                     o_addr, o_be, o_wd_r, o_wd_n);
        end
    endtask

    task automatic test_sh_wait;
        drive_store(2'b01, 32'h0000_0022, 32'h0000_BEEF, 4, 1'b0);
        checks++;
        if (o_be !== 4'b1100 || o_wd_r !== 32'hBEEF_BEEF || o_wd_n !== 32'hBEEF_0000 || o_addr !== 32'h0000_0020) begin
            errors++;
            $display("FAIL sh_lanes: be=%b wd=%h/%h addr=%h, required 1100 beefbeef/beef0000 00000020", o_be, o_wd_r, o_wd_n, o_addr);
        end
        checks++;
        if (o_unstable !== 1'b0 || o_stall_bad !== 1'b0 || o_req_cycles !== 4 || o_done_cycle !== 5) begin
            errors++;
            $display("FAIL sh_wait: unstable=%b stall_bad=%b req_cycles=%0d done_cycle=%0d, required 0 0 4 5",
                     o_unstable, o_stall_bad, o_req_cycles, o_done_cycle);
        end
    endtask

    task automatic test_illegal;
        logic [1:0]  ops [2]   = '{2'b01, 2'b11};
        logic [31:0] addrs [2] = '{32'h0000_0021, 32'h0000_0040};
        for (int k = 0; k < 2; k++) begin
            drive_store(ops[k], addrs[k], 32'h5555_AAAA, 1, 1'b0);
            checks++;
            if (o_req_cycles !== 0 || o_done_cycle !== 1 || o_fault !== 1'b1 || o_after_done !== 1'b0) begin
                errors++;
                $display("FAIL illegal_%0d: req_cycles=%0d done_cycle=%0d fault=%b after=%b, required 0 1 1 0",
                         k, o_req_cycles, o_done_cycle, o_fault, o_after_done);
            end
        end
    endtask

    task automatic test_reset_busy;
        @(posedge clk); #1;
        st_valid = 1'b1; st_op = 2'b00; st_addr = 32'h0000_0040; st_data = 32'h55AA_55AA; mem_ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (r_mem_req !== 1'b1 || r_mem_be !== 4'b1111) begin
            errors++;
            $display("FAIL busy_before_reset: req=%b be=%b, required 1 1111", r_mem_req, r_mem_be);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (r_mem_req !== 1'b0 || r_mem_be !== 4'b0 || r_st_done !== 1'b0 || r_mem_we !== 1'b0 || n_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: req=%b be=%b done=%b we=%b, required all 0", r_mem_req, r_mem_be, r_st_done, r_mem_we);
        end
        st_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        drive_store(2'b00, 32'h0000_0100, 32'hCAFE_F00D, 2, 1'b0);
        checks++;
        if (o_done_cycle !== 3 || o_fault !== 1'b0 || o_be !== 4'b1111 || o_wd_r !== 32'hCAFE_F00D || o_addr !== 32'h100) begin
            errors++;
            $display("FAIL after_reset_sw: done_cycle=%0d fault=%b be=%b wd=%h addr=%h, required 3 0 1111 cafef00d 00000100",
                     o_done_cycle, o_fault, o_be, o_wd_r, o_addr);
        end
    endtask

    task automatic test_spurious_ack;
        logic bad;
        bad = 1'b0;
        @(posedge clk); #1;
        st_valid = 1'b0; mem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (r_st_done !== 1'b0 || r_mem_req !== 1'b0 || r_st_stall !== 1'b0) bad = 1'b1;
        end
        mem_ack = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL idle_spurious_ack: reaction=%b, required 0", bad);
        end
        drive_store(2'b10, 32'h0000_0201, 32'h0000_0077, 2, 1'b1);
        checks++;
        if (o_done_cycle !== 3 || o_req_cycles !== 2 || o_after_done !== 1'b0 || o_be !== 4'b0010) begin
            errors++;
            $display("FAIL done_spurious_ack: done_cycle=%0d req_cycles=%0d after=%b be=%b, required 3 2 0 0010",
                     o_done_cycle, o_req_cycles, o_after_done, o_be);
        end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] addr, data, wd_r, wd_n;
        logic [3:0]  be;
        bit          legal;
        int          dly;
        for (int it = 0; it < 40; it++) begin
            op   = 2'($urandom_range(0, 3));
            addr = $urandom;
            data = $urandom;
            dly  = $urandom_range(1, 3);
            model(op, addr, data, 1'b1, legal, be, wd_r);
            model(op, addr, data, 1'b0, legal, be, wd_n);
            drive_store(op, addr, data, dly, it[0]);
            checks++;
            if (legal) begin
                if (o_done_cycle !== dly + 1 || o_fault !== 1'b0 || o_req_cycles !== dly || o_be !== be
                    || o_wd_r !== wd_r || o_wd_n !== wd_n || o_addr !== {addr[31:2], 2'b00}
                    || o_unstable !== 1'b0 || o_stall_bad !== 1'b0 || o_after_done !== 1'b0) begin
                    errors++;
                    $display("FAIL random_%0d op=%0d addr=%h: done=%0d fault=%b be=%b wd=%h/%h, required done=%0d fault=0 be=%b wd=%h/%h",
                             it, op, addr, o_done_cycle, o_fault, o_be, o_wd_r, o_wd_n, dly + 1, be, wd_r, wd_n);
                end
            end else begin
                if (o_done_cycle !== 1 || o_fault !== 1'b1 || o_req_cycles !== 0 || o_after_done !== 1'b0) begin
                    errors++;
                    $display("FAIL random_%0d illegal op=%0d addr=%h: done=%0d fault=%b req_cycles=%0d, required 1 1 0",
                             it, op, addr, o_done_cycle, o_fault, o_req_cycles);
                end
            end
        end
    endtask

    initial begin
        rstn = 1'b0; st_valid = 1'b0; st_op = 2'b00; st_addr = 32'h0; st_data = 32'h0; mem_ack = 1'b0;
        #12;
        test_reset;
        @(negedge clk);
        rstn = 1'b1;
        test_sw;
        test_sb;
        test_sh_wait;
        test_illegal;
        test_reset_busy;
        test_spurious_ack;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_lane_unit.md
Name: store_lane_unit

Overview:
- Store-side counterpart of the immediate/load extenders: narrows a 32-bit register operand to word, halfword or byte and places it on the correct byte lanes with byte enables.
- Sits between the MEM stage and the data-memory port.
- Runs a request/acknowledge handshake with the memory and stalls the pipeline until the write completes or faults.

Parameters:
- ADDR_W, 32, address width of st_addr and mem_addr.
- REPLICATE, 1, 1 = narrow data replicated to all lanes; 0 = unused lanes of mem_wdata driven 0.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- st_valid  input  1  store request from MEM stage; held high while st_stall is 1.
- st_op  input  2  store size: ST_W=2'b00, ST_H=2'b01, ST_B=2'b10, 2'b11 reserved.
- st_addr  input  ADDR_W  byte address.
- st_data  input  32  register operand (rt).
- st_stall  output  1  combinational: st_valid & ~st_done.
- st_done  output  1  registered one-cycle completion pulse.
- st_fault  output  1  registered; high with st_done when the request was misaligned or illegal.
- mem_req  output  1  registered write request.
- mem_we  output  1  equals mem_req.
- mem_addr  output  ADDR_W  word address {st_addr[ADDR_W-1:2],2'b00}.
- mem_wdata  output  32  lane-placed data.
- mem_be  output  4  byte enables; 0 whenever mem_req=0.
- mem_ack  input  1  memory accepted write this cycle (sampled only while mem_req=1).

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; mem_req, mem_we, mem_be, st_done, st_fault = 0; mem_addr, mem_wdata = 0.
  - Reset mid-operation drops mem_req immediately and abandons the in-flight write.
- States:
  - IDLE: st_valid=1 and request legal → latch packed fields into mem_*, mem_req<=1, go BUSY. st_valid=1 and request illegal → no memory access, st_done<=1, st_fault<=1, go DONE. st_valid=0 → stay.
  - BUSY: mem_* held stable. mem_ack=1 → mem_req<=0, mem_be<=0, st_done<=1, go DONE. mem_addr/mem_wdata keep their last value.
  - DONE: st_done=1 for exactly this cycle; unconditionally → IDLE, clearing st_done and st_fault. st_valid is ignored in DONE; the pipeline advances at the end of this cycle.
- Legality:
  - ST_H needs st_addr[0]=0; ST_W needs st_addr[1:0]=0; ST_B always legal.
  - st_op=2'b11 is illegal.
- Lane packing, with a = st_addr[1:0]:
  - ST_W: wdata = st_data, be = 4'b1111.
  - ST_H: be = a[1] ? 4'b1100 : 4'b0011. REPLICATE=1 → wdata = {2{st_data[15:0]}}; else the halfword goes in the selected lanes and other lanes are 0.
  - ST_B: be = 4'b0001<<a. REPLICATE=1 → wdata = {4{st_data[7:0]}}; else the byte goes in lane a and other lanes are 0.
- Latency:
  - Accept at cycle 0, mem_req high from cycle 1.
  - mem_ack at cycle k≥1 → st_done at k+1. Minimum 3 cycles valid→done; fault path 2 cycles (done at cycle 1).
- mem_ack while mem_req=0 is ignored.
- No back-to-back accept: at most one write outstanding.

Decomposition:
- Shared package (alongside the existing control encodings):
  - ST_W/ST_H/ST_B/ST_RSV st_op encodings.
  - FSM state encodings S_IDLE/S_BUSY/S_DONE.
- Sub-module st_lane_pack, purely combinational: st_op, addr[1:0], st_data → wdata, be, legal. Instantiated once; the top holds the FSM and registers.

Test Plan:
- SW addr=0x1000_0004, data=0xDEADBEEF, ack on first req cycle → mem_addr=0x1000_0004, be=1111, wdata=0xDEADBEEF, st_done at cycle 2, st_fault=0.
- SB addr=0x0000_0013, data=0x1234_56A5, REPLICATE=1 → mem_addr=0x0000_0010, be=1000, wdata=0xA5A5A5A5; REPLICATE=0 → wdata=0xA500_0000.
- SH addr=0x0000_0022, data=0x0000_BEEF, ack delayed 4 cycles → be=1100, wdata=0xBEEFBEEF, mem_* stable through the wait, st_stall high until the st_done cycle.
- SH addr=0x0000_0021 and st_op=2'b11 → mem_req never asserts; st_done=st_fault=1 at cycle 1, then back to IDLE.
- rstn low during BUSY → mem_req/mem_be/st_done drop to 0 asynchronously without a clock edge; after release, a new SW is accepted normally.
- Spurious mem_ack pulses in IDLE and DONE → no state change, no st_done.
